i2c_target_regs: RTL and testbench
==================================

Name: i2c_target_regs

Overview:
I2C target (slave) endpoint: the responder on the same two-wire bus that the system's I2C host controller drives. It decodes START, STOP and address, and ACKs its own 7-bit address. It exposes a byte-addressed register port to local logic with an auto-incrementing pointer. Bus pins are open-drain style: oe=1 pulls the line low, and the pad ring does the tristating.

Parameters:
TARGET_ADDR, 7'h50, 7-bit bus address this block ACKs
FILTER_LEN, 3, clk_clk cycles a synchronized SCL/SDA level must hold before the filtered value changes

Ports:
clk_clk  in  1  system clock; sole clock domain
reset_reset_n  in  1  synchronous, active-low reset
i2c_sda_in  in  1  SDA pad level (asynchronous)
i2c_scl_in  in  1  SCL pad level (asynchronous)
i2c_sda_oe  out  1  1 = pull SDA low
i2c_scl_oe  out  1  1 = pull SCL low; no clock stretching, tied 0
reg_wr_valid  out  1  one-cycle write strobe
reg_wr_addr  out  8  write register address, valid with strobe
reg_wr_data  out  8  write data, valid with strobe
reg_rd_addr  out  8  read pointer presented to local logic
reg_rd_data  in  8  combinational register contents at reg_rd_addr
busy  out  1  high from address match until STOP or next START

Behaviour:
- Reset (reset_reset_n=0 at a clk_clk edge): state=IDLE, pointer=0, i2c_sda_oe=0, i2c_scl_oe=0, reg_wr_valid=0, reg_wr_addr=0, reg_wr_data=0, busy=0. Filters load 1 (bus idle). Reset mid-transfer releases SDA on the next edge. No write strobe is issued for any partial byte.
- Input path per line: 2-flop synchronizer, then glitch filter. The filtered output changes only after FILTER_LEN consecutive equal synchronized samples. Edge detects are taken on the filtered signals.
- START: filtered SDA falls while filtered SCL=1. Goes to ADDR from any state (repeated START included). Bit counter clears. busy=0 until the address matches.
- STOP: filtered SDA rises while filtered SCL=1. Goes to IDLE from any state. Releases SDA and clears busy. Pointer is retained.
- Bit timing: SDA is sampled on the filtered SCL rising edge. i2c_sda_oe changes only on the clk_clk cycle after a filtered SCL falling edge.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, WAIT_STOP.
- ADDR: shift in 8 bits, MSB first (7 address bits, then R/W).
  - Match: ACK (drive SDA low for the 9th clock) and set busy. R/W=0 goes to PTR; R/W=1 goes to RDATA.
  - Mismatch: no ACK; go to WAIT_STOP, which ignores all activity until START or STOP.
- PTR: 8 bits load the pointer, then ACK, then WDATA.
- WDATA: 8 bits, then ACK.
  - One clk_clk after the 8th rising edge: reg_wr_valid=1 for exactly one cycle, reg_wr_addr=pointer, reg_wr_data=byte.
  - Pointer then increments mod 256 (0xFF goes to 0x00). Remains in WDATA until START/STOP.
- RDATA:
  - On the SCL falling edge that ends the address ACK (or a master ACK), capture reg_rd_data (addressed by reg_rd_addr=pointer) into the shift register.
  - Drive each bit with i2c_sda_oe = ~bit, MSB first.
  - After 8 bits, release SDA and enter RACK.
- RACK: sample the master's 9th bit.
  - 0 (ACK): pointer+1 mod 256, back to RDATA.
  - 1 (NACK): WAIT_STOP with SDA released; pointer is still incremented.
- reg_rd_addr always equals the pointer.
- ACK drive is held from the falling edge after bit 8 to the falling edge after bit 9, then released.
- i2c_scl_oe is constant 0 in every state.

Test Plan:
- Write: START, 0xA0, ptr 0x10, data 0x5A, 0x3C, STOP → ACK on all 4 bytes. Strobes (0x10,0x5A) then (0x11,0x3C). busy falls at STOP.
- Random read: ptr 0x20 write, repeated START, 0xA1, reg model returns 0x20→0x11 and 0x21→0x22; master ACK then NACK → SDA shows 0x11 then 0x22. No strobe. Pointer ends at 0x22.
- Wrong address: START, 0xA4, data 0x77, STOP → SDA never driven. No strobe. busy stays 0.
- Wrap: ptr 0xFF, data 0x01, 0x02 → strobes at 0xFF then 0x00.
- Abort and glitch: STOP after 5 bits of a data byte → no strobe, IDLE. A 2-cycle SCL glitch (FILTER_LEN=3) → no bit shifted.
- Reset mid-read while driving a 0 bit → i2c_sda_oe=0 the next cycle. Pointer=0. A new transfer after reset works normally.

Source files
------------

// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target endpoint exposing a byte-addressed register port with an auto-incrementing pointer
// Ports:
//   clk_clk, reset_reset_n    system clock, synchronous active-low reset
//   i2c_sda_in, i2c_scl_in    asynchronous pad levels
//   i2c_sda_oe, i2c_scl_oe    open-drain pull-low enables (SCL is never stretched)
//   reg_wr_valid/addr/data    one-cycle register write strobe with address and data
//   reg_rd_addr, reg_rd_data  read pointer out, combinational register contents in
//   busy                      high while this target is addressed
module i2c_target_regs #(
    parameter logic [6:0] TARGET_ADDR = 7'h50,
    parameter int         FILTER_LEN  = 3
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic       i2c_sda_in,
    input  logic       i2c_scl_in,
    output logic       i2c_sda_oe,
    output logic       i2c_scl_oe,
    output logic       reg_wr_valid,
    output logic [7:0] reg_wr_addr,
    output logic [7:0] reg_wr_data,
    output logic [7:0] reg_rd_addr,
    input  logic [7:0] reg_rd_data,
    output logic       busy
);
    localparam int CW = $clog2(FILTER_LEN + 1);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, WAIT_STOP
    } state_t;

    // index 0 = SDA, index 1 = SCL
    logic [1:0]    w_pad;
    logic [1:0]    r_s1, r_s2, r_flt, r_flt_d;
    logic [CW-1:0] r_cnt [2];
    logic          w_sda, w_scl, w_start, w_stop, w_rise, w_fall;

    state_t     r_state;
    logic [3:0] r_bit;
    logic [7:0] r_shift, r_ptr, r_wr_addr, r_wr_data;
    logic       r_rw, r_ack_n, r_sda_oe, r_wr_valid, r_busy;

    assign w_pad   = {i2c_scl_in, i2c_sda_in};
    assign w_sda   = r_flt[0];
    assign w_scl   = r_flt[1];
    assign w_start = w_scl & r_flt_d[1] & r_flt_d[0] & ~w_sda;
    assign w_stop  = w_scl & r_flt_d[1] & ~r_flt_d[0] & w_sda;
    assign w_rise  = w_scl & ~r_flt_d[1];
    assign w_fall  = ~w_scl & r_flt_d[1];

    // Filtered level follows the synchronized level only after FILTER_LEN consecutive differing samples
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_s1    <= 2'b11;
            r_s2    <= 2'b11;
            r_flt   <= 2'b11;
            r_flt_d <= 2'b11;
            for (int i = 0; i < 2; i++) r_cnt[i] <= '0;
        end else begin
            r_s1    <= w_pad;
            r_s2    <= r_s1;
            r_flt_d <= r_flt;
            for (int i = 0; i < 2; i++) begin
                if (r_s2[i] == r_flt[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CW'(FILTER_LEN - 1)) begin
                    r_flt[i] <= r_s2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_state    <= IDLE;
            r_bit      <= '0;
            r_shift    <= '0;
            r_ptr      <= '0;
            r_rw       <= 1'b0;
            r_ack_n    <= 1'b1;
            r_sda_oe   <= 1'b0;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_wr_valid <= 1'b0;
            if (w_start) begin
                r_state  <= ADDR;
                r_bit    <= '0;
                r_busy   <= 1'b0;
                r_sda_oe <= 1'b0;
            end else if (w_stop) begin
                r_state  <= IDLE;
                r_busy   <= 1'b0;
                r_sda_oe <= 1'b0;
            end else if (w_rise) begin
                case (r_state)
                    ADDR, PTR, WDATA: begin
                        r_shift <= {r_shift[6:0], w_sda};
                        r_bit   <= r_bit + 4'd1;
                        if (r_state == WDATA && r_bit == 4'd7) begin
                            r_wr_valid <= 1'b1;
                            r_wr_addr  <= r_ptr;
                            r_wr_data  <= {r_shift[6:0], w_sda};
                            r_ptr      <= r_ptr + 8'd1;
                        end
                    end
                    RDATA: r_bit <= r_bit + 4'd1;
                    // Advance before the falling edge so reg_rd_data already reflects the next byte
                    RACK: begin
                        r_ack_n <= w_sda;
                        r_ptr   <= r_ptr + 8'd1;
                    end
                    default: ;
                endcase
            end else if (w_fall) begin
                case (r_state)
                    ADDR: if (r_bit == 4'd8) begin
                        if (r_shift[7:1] == TARGET_ADDR) begin
                            r_state  <= ADDR_ACK;
                            r_rw     <= r_shift[0];
                            r_sda_oe <= 1'b1;
                            r_busy   <= 1'b1;
                        end else begin
                            r_state <= WAIT_STOP;
                        end
                    end
                    ADDR_ACK: begin
                        r_bit <= '0;
                        if (r_rw) begin
                            r_state  <= RDATA;
                            r_shift  <= reg_rd_data;
                            r_sda_oe <= ~reg_rd_data[7];
                        end else begin
                            r_state  <= PTR;
                            r_sda_oe <= 1'b0;
                        end
                    end
                    PTR: if (r_bit == 4'd8) begin
                        r_state  <= PTR_ACK;
                        r_ptr    <= r_shift;
                        r_sda_oe <= 1'b1;
                    end
                    WDATA: if (r_bit == 4'd8) begin
                        r_state  <= WDATA_ACK;
                        r_sda_oe <= 1'b1;
                    end
                    PTR_ACK, WDATA_ACK: begin
                        r_state  <= WDATA;
                        r_bit    <= '0;
                        r_sda_oe <= 1'b0;
                    end
                    // Bit 7 goes out on entry; each later falling edge presents the next bit
                    RDATA: if (r_bit == 4'd8) begin
                        r_state  <= RACK;
                        r_sda_oe <= 1'b0;
                    end else begin
                        r_sda_oe <= ~r_shift[6];
                        r_shift  <= {r_shift[6:0], 1'b0};
                    end
                    RACK: if (r_ack_n) begin
                        r_state  <= WAIT_STOP;
                        r_sda_oe <= 1'b0;
                    end else begin
                        r_state  <= RDATA;
                        r_bit    <= '0;
                        r_shift  <= reg_rd_data;
                        r_sda_oe <= ~reg_rd_data[7];
                    end
                    default: ;
                endcase
            end
        end
    end

    assign i2c_sda_oe   = r_sda_oe;
    assign i2c_scl_oe   = 1'b0;
    assign reg_wr_valid = r_wr_valid;
    assign reg_wr_addr  = r_wr_addr;
    assign reg_wr_data  = r_wr_data;
    assign reg_rd_addr  = r_ptr;
    assign busy         = r_busy;
endmodule

// File: tb/tb_i2c_target_regs.sv
// tb_i2c_target_regs: bus-level bench for i2c_target_regs with a transaction-level register/pointer model
module tb_i2c_target_regs;
    localparam int Q = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sda_m, scl_m, sda_bus;
    logic       i2c_sda_oe, i2c_scl_oe;
    logic       reg_wr_valid;
    logic [7:0] reg_wr_addr, reg_wr_data, reg_rd_addr, reg_rd_data;
    logic       busy;

    logic [7:0]  mem [256];
    logic [7:0]  wbuf [4];
    logic [15:0] wr_q [$];
    logic [15:0] exp_q [$];
    logic [7:0]  mptr;
    logic        oe_seen, busy_seen, scl_bad;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    assign sda_bus     = sda_m & ~i2c_sda_oe;
    assign reg_rd_data = mem[reg_rd_addr];

    i2c_target_regs #(.TARGET_ADDR(7'h50), .FILTER_LEN(3)) dut (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .i2c_sda_in(sda_bus), .i2c_scl_in(scl_m),
        .i2c_sda_oe(i2c_sda_oe), .i2c_scl_oe(i2c_scl_oe),
        .reg_wr_valid(reg_wr_valid), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
        .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data), .busy(busy)
    );

    always @(negedge clk) begin
        if (i2c_sda_oe) oe_seen = 1'b1;
        if (busy) busy_seen = 1'b1;
        if (i2c_scl_oe) scl_bad = 1'b1;
        if (reg_wr_valid) wr_q.push_back({reg_wr_addr, reg_wr_data});
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wq(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_x(input logic b, output logic r);
        sda_m = b;
        wq(Q);
        scl_m = 1'b1;
        wq(Q);
        r = sda_bus;
        wq(Q);
        scl_m = 1'b0;
        wq(Q);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        wq(Q);
        scl_m = 1'b1;
        wq(Q);
        sda_m = 1'b0;
        wq(Q);
        scl_m = 1'b0;
        wq(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        wq(Q);
        scl_m = 1'b1;
        wq(Q);
        sda_m = 1'b1;
        wq(Q);
    endtask

    task automatic wbyte(input logic [7:0] v, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_x(v[i], r);
        bit_x(1'b1, ack);
    endtask

    task automatic rbyte(input logic ackbit, output logic [7:0] b);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_x(1'b1, r);
            b[i] = r;
        end
        bit_x(ackbit, r);
    endtask

    task automatic cmp_strobes();
        chk("strobe_count", wr_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < wr_q.size()) chk("strobe", wr_q[i], exp_q[i]);
    endtask

    // Write transaction: wbuf[0] is the pointer byte, wbuf[1..n] are data bytes
    task automatic wr_xact(input logic [7:0] ab, input int n, output logic addr_ack);
        logic own, a;
        own = (ab[7:1] == 7'h50) && !ab[0];
        wr_q.delete();
        exp_q.delete();
        oe_seen = 1'b0;
        busy_seen = 1'b0;
        i2c_start();
        wbyte(ab, addr_ack);
        chk("addr_ack", addr_ack, !own);
        chk("busy_mid", busy, own);
        wbyte(wbuf[0], a);
        chk("ptr_ack", a, !own);
        if (own) mptr = wbuf[0];
        for (int i = 1; i <= n; i++) begin
            wbyte(wbuf[i], a);
            chk("data_ack", a, !own);
            if (own) begin
                exp_q.push_back({mptr, wbuf[i]});
                mptr = mptr + 8'd1;
            end
        end
        i2c_stop();
        wq(Q);
        cmp_strobes();
        chk("busy_after_stop", busy, 1'b0);
        chk("ptr_end", reg_rd_addr, mptr);
    endtask

    task automatic rd_xact(input logic [7:0] ptr, input int k);
        logic a;
        logic [7:0] b;
        wr_q.delete();
        i2c_start();
        wbyte(8'hA0, a);
        wbyte(ptr, a);
        mptr = ptr;
        i2c_start();
        wbyte(8'hA1, a);
        chk("rd_addr_ack", a, 1'b0);
        for (int i = 0; i < k; i++) begin
            rbyte(i == k - 1, b);
            chk("rd_byte", b, mem[mptr]);
            mptr = mptr + 8'd1;
        end
        i2c_stop();
        wq(Q);
        chk("rd_no_strobe", wr_q.size(), 0);
        chk("rd_ptr_end", reg_rd_addr, mptr);
        chk("rd_sda_released", i2c_sda_oe, 1'b0);
    endtask

    typedef struct {
        logic [7:0] ab, ptr;
        int         n;
        logic [7:0] d0, d1;
        logic       exp_ack;
        int         exp_nstb;
        logic [7:0] exp_ptr;
        logic       exp_oe;
        logic       exp_busy;
    } vec_t;

    initial begin
        vec_t tv [4];
        logic a;
        logic [7:0] b;
        tv[0] = '{8'hA0, 8'h10, 2, 8'h5A, 8'h3C, 1'b0, 2, 8'h12, 1'b1, 1'b1};
        tv[1] = '{8'hA0, 8'hFF, 2, 8'h01, 8'h02, 1'b0, 2, 8'h01, 1'b1, 1'b1};
        tv[2] = '{8'hA4, 8'h77, 0, 8'h00, 8'h00, 1'b1, 0, 8'h01, 1'b0, 1'b0};
        tv[3] = '{8'hA0, 8'h20, 0, 8'h00, 8'h00, 1'b0, 0, 8'h20, 1'b1, 1'b1};
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        scl_bad = 1'b0;
        sda_m = 1'b1;
        scl_m = 1'b1;
        rst_n = 1'b0;
        mptr = 8'h00;
        wq(4);
        chk("rst_sda_oe", i2c_sda_oe, 1'b0);
        chk("rst_scl_oe", i2c_scl_oe, 1'b0);
        chk("rst_wr_valid", reg_wr_valid, 1'b0);
        chk("rst_wr_addr", reg_wr_addr, 8'h00);
        chk("rst_wr_data", reg_wr_data, 8'h00);
        chk("rst_rd_addr", reg_rd_addr, 8'h00);
        chk("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        wq(10);

        for (int t = 0; t < 4; t++) begin
            wbuf[0] = tv[t].ptr;
            wbuf[1] = tv[t].d0;
            wbuf[2] = tv[t].d1;
            wr_xact(tv[t].ab, tv[t].n, a);
            chk("tv_ack", a, tv[t].exp_ack);
            chk("tv_nstb", wr_q.size(), tv[t].exp_nstb);
            chk("tv_ptr", reg_rd_addr, tv[t].exp_ptr);
            chk("tv_oe_seen", oe_seen, tv[t].exp_oe);
            chk("tv_busy_seen", busy_seen, tv[t].exp_busy);
        end
        chk("write_first", (wr_q.size() == 0) ? 1'b1 : 1'b0, 1'b1);

        mem[8'h20] = 8'h11;
        mem[8'h21] = 8'h22;
        rd_xact(8'h20, 2);
        chk("read_ptr_22", reg_rd_addr, 8'h22);

        // Abort: STOP after 5 bits of a data byte
        wr_q.delete();
        i2c_start();
        wbyte(8'hA0, a);
        wbyte(8'h40, a);
        mptr = 8'h40;
        for (int i = 0; i < 5; i++) bit_x(i[0], a);
        i2c_stop();
        wq(Q);
        chk("abort_no_strobe", wr_q.size(), 0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_ptr", reg_rd_addr, 8'h40);

        // 2-cycle SCL glitch inside a data byte must not shift a bit
        wr_q.delete();
        exp_q.delete();
        i2c_start();
        wbyte(8'hA0, a);
        wbyte(8'h60, a);
        b = 8'h81;
        for (int i = 7; i >= 0; i--) begin
            if (i == 3) begin
                scl_m = 1'b1;
                wq(2);
                scl_m = 1'b0;
                wq(Q);
            end
            bit_x(b[i], a);
        end
        bit_x(1'b1, a);
        chk("glitch_ack", a, 1'b0);
        i2c_stop();
        wq(Q);
        exp_q.push_back(16'h6081);
        cmp_strobes();
        mptr = 8'h61;
        chk("glitch_ptr", reg_rd_addr, mptr);

        // Randomized transactions against the model
        for (int t = 0; t < 14; t++) begin
            int r, n, k;
            logic [6:0] a7;
            r = $urandom_range(0, 9);
            if (r == 0) begin
                a7 = 7'($urandom_range(0, 127));
                if (a7 == 7'h50) a7 = 7'h51;
                wbuf[0] = 8'($urandom);
                wr_xact({a7, 1'($urandom)}, 1, a);
                chk("rand_noack_oe", oe_seen, 1'b0);
            end else if (r < 5) begin
                n = $urandom_range(0, 3);
                for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
                wr_xact(8'hA0, n, a);
            end else begin
                k = $urandom_range(1, 3);
                rd_xact(8'($urandom), k);
            end
        end

        // Reset while driving a 0 data bit
        mem[mptr] = 8'h3C;
        i2c_start();
        wbyte(8'hA1, a);
        chk("mid_read_driving", i2c_sda_oe, 1'b1);
        rst_n = 1'b0;
        wq(1);
        chk("mid_reset_oe", i2c_sda_oe, 1'b0);
        chk("mid_reset_ptr", reg_rd_addr, 8'h00);
        chk("mid_reset_busy", busy, 1'b0);
        sda_m = 1'b1;
        scl_m = 1'b1;
        wq(3);
        rst_n = 1'b1;
        wq(10);
        mptr = 8'h00;
        wbuf[0] = 8'h05;
        wbuf[1] = 8'h99;
        wr_xact(8'hA0, 1, a);
        chk("post_reset_strobe", (wr_q.size() > 0) ? wr_q[0] : 16'h0000, 16'h0599);

        chk("scl_never_driven", scl_bad, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
